// File: rtl/cpu_controller_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared types and encodings for the cpu_controller FSM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef logic [2:0] opcode_t;
    typedef logic [1:0] op_t;
    typedef logic [1:0] nsel_t;
    typedef logic [1:0] vsel_t;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_RD  = 3'd6
    } state_t;

    localparam opcode_t C_OPC_MOV = 3'b110;
    localparam opcode_t C_OPC_ALU = 3'b101;

    localparam op_t C_OP_MOV_REG = 2'b00;
    localparam op_t C_OP_MOVI    = 2'b10;
    localparam op_t C_OP_ADD     = 2'b00;
    localparam op_t C_OP_CMP     = 2'b01;
    localparam op_t C_OP_AND     = 2'b10;
    localparam op_t C_OP_MVN     = 2'b11;

    localparam nsel_t C_NSEL_RM = 2'b00;
    localparam nsel_t C_NSEL_RD = 2'b01;
    localparam nsel_t C_NSEL_RN = 2'b10;

    localparam vsel_t C_VSEL_C   = 2'b00;
    localparam vsel_t C_VSEL_IMM = 2'b10;

    // First state after DECODE; unknown codes fall straight back to WAIT.
    function automatic state_t decode_next(input opcode_t opc, input op_t sub);
        state_t nxt;
        nxt = S_WAIT;
        if (opc == C_OPC_MOV) begin
            if (sub == C_OP_MOVI)         nxt = S_WRITE_IMM;
            else if (sub == C_OP_MOV_REG) nxt = S_GET_B;
        end else if (opc == C_OPC_ALU) begin
            if (sub == C_OP_MVN) nxt = S_GET_B;
            else                 nxt = S_GET_A;
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_controller_if.sv
// ============================================================================
// Module : cpu_controller_if
// Brief  : Decoder/datapath handshake bundle around the controller FSM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_controller_if;
    import cpu_pkg::*;

    logic    s;
    opcode_t opcode;
    op_t     op;
    logic    w;
    nsel_t   nsel;
    logic    loada;
    logic    loadb;
    logic    loadc;
    logic    loads;
    logic    asel;
    logic    bsel;
    vsel_t   vsel;
    logic    write;

    modport master (
        input  s, opcode, op,
        output w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write
    );

    modport slave (
        output s, opcode, op,
        input  w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write
    );

endinterface

`default_nettype wire

// File: rtl/cpu_controller.sv
// ============================================================================
// Module : cpu_controller
// Brief  : Moore FSM sequencing register loads and writeback per instruction.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_controller
    import cpu_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          reset,
    cpu_controller_if.master   bus
);

    state_t  state_q, state_d;
    opcode_t opcode_q, opcode_d;
    op_t     op_q, op_d;

    logic    w_is_cmp;
    logic    w_zero_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_WAIT;
            opcode_q <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            op_q     <= op_d;
        end
    end

    assign w_is_cmp = (opcode_q == C_OPC_ALU) && (op_q == C_OP_CMP);
    // MOV reg and MVN pass B through the ALU, so A is forced to zero.
    assign w_zero_a = ((opcode_q == C_OPC_MOV) && (op_q == C_OP_MOV_REG)) ||
                      ((opcode_q == C_OPC_ALU) && (op_q == C_OP_MVN));

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        op_d     = op_q;
        case (state_q)
            S_WAIT: begin
                if (bus.s) begin
                    state_d  = S_DECODE;
                    opcode_d = bus.opcode;
                    op_d     = bus.op;
                end
            end
            S_DECODE:    state_d = decode_next(opcode_q, op_q);
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU:       state_d = w_is_cmp ? S_WAIT : S_WRITE_RD;
            S_WRITE_RD:  state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    always_comb begin
        bus.w     = 1'b0;
        bus.nsel  = C_NSEL_RM;
        bus.loada = 1'b0;
        bus.loadb = 1'b0;
        bus.loadc = 1'b0;
        bus.loads = 1'b0;
        bus.asel  = 1'b0;
        bus.bsel  = 1'b0;
        bus.vsel  = C_VSEL_C;
        bus.write = 1'b0;
        case (state_q)
            S_WAIT: bus.w = 1'b1;
            S_WRITE_IMM: begin
                bus.nsel  = C_NSEL_RN;
                bus.vsel  = C_VSEL_IMM;
                bus.write = 1'b1;
            end
            S_GET_A: begin
                bus.nsel  = C_NSEL_RN;
                bus.loada = 1'b1;
            end
            S_GET_B: begin
                bus.nsel  = C_NSEL_RM;
                bus.loadb = 1'b1;
            end
            S_ALU: begin
                bus.asel  = w_zero_a;
                bus.loads = w_is_cmp;
                bus.loadc = ~w_is_cmp;
            end
            S_WRITE_RD: begin
                bus.nsel  = C_NSEL_RD;
                bus.vsel  = C_VSEL_C;
                bus.write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_controller.sv
// ============================================================================
// Module : tb_cpu_controller
// Brief  : Directed self-checking bench for cpu_controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_controller;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   wr_cnt;

    cpu_controller_if bus ();

    cpu_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: {w, nsel[1:0], loada, loadb, loadc, loads, asel, bsel, vsel[1:0], write}
    logic [11:0] obs;
    assign obs = {bus.w, bus.nsel, bus.loada, bus.loadb, bus.loadc, bus.loads,
                  bus.asel, bus.bsel, bus.vsel, bus.write};

    localparam logic [11:0] V_IDLE   = 12'b1_00_0000_00_00_0;
    localparam logic [11:0] V_DEC    = 12'b0_00_0000_00_00_0;
    localparam logic [11:0] V_WIMM   = 12'b0_10_0000_00_10_1;
    localparam logic [11:0] V_GETA   = 12'b0_10_1000_00_00_0;
    localparam logic [11:0] V_GETB   = 12'b0_00_0100_00_00_0;
    localparam logic [11:0] V_ALUC   = 12'b0_00_0010_00_00_0;
    localparam logic [11:0] V_ALUC0  = 12'b0_00_0010_10_00_0;
    localparam logic [11:0] V_ALUS   = 12'b0_00_0001_00_00_0;
    localparam logic [11:0] V_WRD    = 12'b0_01_0000_00_00_1;

    always @(negedge clk) begin
        if (reset)          wr_cnt <= 0;
        else if (bus.write) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step(input string tag, input logic [11:0] e);
        @(posedge clk);
        #1;
        chk(tag, {20'd0, obs}, {20'd0, e});
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        bus.s      = 1'b1;
        bus.opcode = 3'b111;
        bus.op     = 2'b11;

        // Reset wins over a held start request.
        @(posedge clk);
        step("reset_idle", V_IDLE);
        chk("reset_opcode_q", {29'd0, dut.opcode_q}, 32'd0);
        chk("reset_op_q", {30'd0, dut.op_q}, 32'd0);
        bus.s = 1'b0;
        reset = 1'b0;
        step("wait_hold", V_IDLE);
        step("wait_hold2", V_IDLE);
        wr_cnt = 0;

        // MOVI; inputs scrambled after capture must not matter.
        bus.opcode = 3'b110; bus.op = 2'b10; bus.s = 1'b1;
        step("movi_decode", V_DEC);
        bus.s = 1'b0; bus.opcode = 3'b101; bus.op = 2'b01;
        step("movi_write_imm", V_WIMM);
        step("movi_done", V_IDLE);
        chk("movi_writes", wr_cnt, 32'd1);

        // ADD
        bus.opcode = 3'b101; bus.op = 2'b00; bus.s = 1'b1;
        step("add_decode", V_DEC);
        bus.s = 1'b0;
        step("add_get_a", V_GETA);
        step("add_get_b", V_GETB);
        step("add_alu", V_ALUC);
        step("add_write_rd", V_WRD);
        step("add_done", V_IDLE);
        chk("add_writes", wr_cnt, 32'd2);

        // CMP: status load only, no writeback.
        bus.opcode = 3'b101; bus.op = 2'b01; bus.s = 1'b1;
        step("cmp_decode", V_DEC);
        step("cmp_get_a", V_GETA);
        step("cmp_get_b", V_GETB);
        step("cmp_alu", V_ALUS);
        bus.s = 1'b0;
        step("cmp_done", V_IDLE);
        chk("cmp_writes", wr_cnt, 32'd2);

        // MVN with opcode clobbered mid-instruction.
        bus.opcode = 3'b101; bus.op = 2'b11; bus.s = 1'b1;
        step("mvn_decode", V_DEC);
        bus.s = 1'b0;
        step("mvn_get_b", V_GETB);
        bus.opcode = 3'b000; bus.op = 2'b00;
        step("mvn_alu", V_ALUC0);
        step("mvn_write_rd", V_WRD);
        step("mvn_done", V_IDLE);
        chk("mvn_writes", wr_cnt, 32'd3);

        // MOV reg then illegal 011, back to back with s held high.
        bus.opcode = 3'b110; bus.op = 2'b00; bus.s = 1'b1;
        step("mov_decode", V_DEC);
        step("mov_get_b", V_GETB);
        step("mov_alu", V_ALUC0);
        step("mov_write_rd", V_WRD);
        step("mov_done", V_IDLE);
        bus.opcode = 3'b011; bus.op = 2'b00;
        step("ill_decode", V_DEC);
        bus.s = 1'b0;
        step("ill_done", V_IDLE);
        step("ill_stay", V_IDLE);
        chk("mov_ill_writes", wr_cnt, 32'd4);

        // Reset in GET_B of ADD aborts without writeback.
        bus.opcode = 3'b101; bus.op = 2'b00; bus.s = 1'b1;
        step("abort_decode", V_DEC);
        bus.s = 1'b0;
        step("abort_get_a", V_GETA);
        step("abort_get_b", V_GETB);
        chk("abort_pre_writes", wr_cnt, 32'd4);
        reset = 1'b1;
        step("abort_reset", V_IDLE);
        chk("abort_opcode_q", {29'd0, dut.opcode_q}, 32'd0);
        reset = 1'b0;
        step("abort_idle", V_IDLE);
        step("abort_idle2", V_IDLE);
        chk("abort_writes", wr_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
